// File: rtl/cut_latency_monitor.sv
// Measures CUT latency from the rst_cut release to end_cut and holds the captured result until accepted.
// Optional timeout is compiled in with `define CUT_LATENCY_MONITOR_TIMEOUT_EN.
module cut_latency_monitor #(
    parameter int unsigned DATA_WIDTH     = 88,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h000F_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_cut,
    input  logic                  end_cut,
    input  logic [DATA_WIDTH-1:0] output_from_cut,
    input  logic                  result_ready,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic [CNT_WIDTH-1:0]  result_cycles,
    output logic                  timeout,
    output logic                  aborted,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state;
    state_t               state_nxt;
    logic                 rst_cut_q;
    logic                 start;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 capture_end;
    logic                 capture_timeout;
    logic                 abort_run;
    logic                 timeout_hit;

    assign start        = rst_cut_q & ~rst_cut;
    assign result_valid = (state == DONE);

`ifdef CUT_LATENCY_MONITOR_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT_CYCLES);
    assign timeout_hit = (count == TIMEOUT_CNT);
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
    assign timeout_hit          = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        capture_end     = 1'b0;
        capture_timeout = 1'b0;
        abort_run       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    count_nxt = CNT_ONE;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Abort outranks completion, which outranks timeout.
                if (rst_cut) begin
                    abort_run = 1'b1;
                    state_nxt = IDLE;
                end else if (end_cut) begin
                    capture_end = 1'b1;
                    state_nxt   = DONE;
                end else if (timeout_hit) begin
                    capture_timeout = 1'b1;
                    state_nxt       = DONE;
                end else if (count != CNT_MAX) begin
                    count_nxt = count + CNT_ONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            rst_cut_q     <= 1'b1;
            result_data   <= '0;
            result_cycles <= '0;
            timeout       <= 1'b0;
            aborted       <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            rst_cut_q <= rst_cut;
            aborted   <= abort_run;
            if ((state == DONE) && start) begin
                overrun <= 1'b1;
            end
            if (capture_end) begin
                result_data   <= output_from_cut;
                result_cycles <= count;
                timeout       <= 1'b0;
            end else if (capture_timeout) begin
                // count equals the timeout limit whenever this fires
                result_data   <= '0;
                result_cycles <= count;
                timeout       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cut_latency_monitor.sv
// Directed bench for cut_latency_monitor; inputs change and outputs are sampled on the falling edge.
// Build with CUT_LATENCY_MONITOR_TIMEOUT_EN defined to exercise the timeout path.
module tb_cut_latency_monitor;

    localparam int DW = 88;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rst_cut;
    logic          end_cut;
    logic [DW-1:0] output_from_cut;
    logic          result_ready;
    logic          result_valid;
    logic [DW-1:0] result_data;
    logic [CW-1:0] result_cycles;
    logic          timeout;
    logic          aborted;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    localparam logic [DW-1:0] PAT_A = 88'h123456789ABCDEF0123456;
    localparam logic [DW-1:0] PAT_B = 88'hFEDCBA9876543210FEDCBA;
    localparam logic [DW-1:0] PAT_C = {11{8'hA5}};
    localparam logic [DW-1:0] PAT_D = {11{8'h3C}};

    cut_latency_monitor #(
        .DATA_WIDTH    (DW),
        .CNT_WIDTH     (CW),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rst_cut        (rst_cut),
        .end_cut        (end_cut),
        .output_from_cut(output_from_cut),
        .result_ready   (result_ready),
        .result_valid   (result_valid),
        .result_data    (result_data),
        .result_cycles  (result_cycles),
        .timeout        (timeout),
        .aborted        (aborted),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        rst_cut         = 1'b1;
        end_cut         = 1'b0;
        output_from_cut = '0;
        result_ready    = 1'b0;
        step(2);
        chk("rst_valid",   result_valid,  0);
        chk("rst_data",    result_data,   0);
        chk("rst_cycles",  result_cycles, 0);
        chk("rst_timeout", timeout,       0);
        chk("rst_aborted", aborted,       0);
        chk("rst_overrun", overrun,       0);
        rst = 1'b0;
        step(2);

        // start cycle counts 1, then 40 further cycles before end_cut is seen -> 41
        rst_cut = 1'b0;
        step(41);
        chk("run_valid", result_valid, 0);
        end_cut         = 1'b1;
        output_from_cut = PAT_A;
        step(1);
        end_cut         = 1'b0;
        output_from_cut = PAT_B;
        chk("m1_valid",   result_valid,  1);
        chk("m1_cycles",  result_cycles, 41);
        chk("m1_data",    result_data,   PAT_A);
        chk("m1_timeout", timeout,       0);

        // hold for 10 cycles with end_cut pulsing, then accept
        for (int i = 0; i < 10; i++) begin
            end_cut = i[0];
            step(1);
            chk("hold_valid",  result_valid,  1);
            chk("hold_data",   result_data,   PAT_A);
            chk("hold_cycles", result_cycles, 41);
        end
        end_cut      = 1'b0;
        result_ready = 1'b1;
        step(1);
        result_ready = 1'b0;
        chk("accept_valid",  result_valid,  0);
        chk("accept_data",   result_data,   PAT_A);
        chk("accept_cycles", result_cycles, 41);

        // abort 5 cycles into RUN, with end_cut high in the same cycle
        rst_cut = 1'b1;
        step(1);
        rst_cut = 1'b0;
        step(5);
        rst_cut = 1'b1;
        end_cut = 1'b1;
        step(1);
        end_cut = 1'b0;
        chk("abort_pulse", aborted,      1);
        chk("abort_valid", result_valid, 0);
        step(1);
        chk("abort_clear", aborted,      0);
        chk("abort_valid2", result_valid, 0);
        rst_cut = 1'b0;
        step(10);
        end_cut         = 1'b1;
        output_from_cut = PAT_C;
        step(1);
        end_cut = 1'b0;
        chk("m2_valid",  result_valid,  1);
        chk("m2_cycles", result_cycles, 10);
        chk("m2_data",   result_data,   PAT_C);

        // start edge while DONE is ignored but flagged
        rst_cut = 1'b1;
        step(1);
        rst_cut = 1'b0;
        step(1);
        chk("ovr_flag", overrun, 1);
        step(3);
        chk("ovr_valid",  result_valid,  1);
        chk("ovr_cycles", result_cycles, 10);
        chk("ovr_data",   result_data,   PAT_C);

        // accept and start together: back to IDLE, not RUN
        rst_cut = 1'b1;
        step(1);
        rst_cut      = 1'b0;
        result_ready = 1'b1;
        step(1);
        result_ready    = 1'b0;
        chk("acc_start_valid", result_valid, 0);
        end_cut         = 1'b1;
        output_from_cut = PAT_D;
        step(1);
        end_cut = 1'b0;
        chk("acc_start_idle", result_valid,  0);
        chk("acc_start_data", result_data,   PAT_C);
        chk("acc_start_ovr",  overrun,       1);

        // reset mid-RUN discards everything
        rst_cut = 1'b1;
        step(1);
        rst_cut = 1'b0;
        step(4);
        rst     = 1'b1;
        rst_cut = 1'b1;
        end_cut = 1'b1;
        step(1);
        end_cut = 1'b0;
        chk("rst2_valid",   result_valid,  0);
        chk("rst2_data",    result_data,   0);
        chk("rst2_cycles",  result_cycles, 0);
        chk("rst2_overrun", overrun,       0);
        chk("rst2_timeout", timeout,       0);
        chk("rst2_aborted", aborted,       0);
        rst = 1'b0;
        step(1);

`ifdef CUT_LATENCY_MONITOR_TIMEOUT_EN
        // timeout at count 100 with end_cut held low
        output_from_cut = PAT_B;
        rst_cut         = 1'b0;
        step(100);
        chk("to_not_yet", result_valid, 0);
        step(1);
        chk("to_valid",   result_valid,  1);
        chk("to_flag",    timeout,       1);
        chk("to_cycles",  result_cycles, 100);
        chk("to_data",    result_data,   0);
        result_ready = 1'b1;
        rst_cut      = 1'b1;
        step(1);
        result_ready = 1'b0;

        // end_cut on the counter=100 cycle wins over timeout
        rst_cut = 1'b0;
        step(100);
        chk("tie_not_yet", result_valid, 0);
        end_cut         = 1'b1;
        output_from_cut = PAT_D;
        step(1);
        end_cut = 1'b0;
        chk("tie_valid",  result_valid,  1);
        chk("tie_flag",   timeout,       0);
        chk("tie_cycles", result_cycles, 100);
        chk("tie_data",   result_data,   PAT_D);
`else
        // 8-bit counter saturates at 255
        rst_cut = 1'b0;
        step(300);
        chk("sat_not_yet", result_valid, 0);
        end_cut         = 1'b1;
        output_from_cut = PAT_D;
        step(1);
        end_cut = 1'b0;
        chk("sat_valid",   result_valid,  1);
        chk("sat_cycles",  result_cycles, 255);
        chk("sat_data",    result_data,   PAT_D);
        chk("sat_timeout", timeout,       0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cut_latency_monitor.md
CUT_LATENCY_MONITOR -- requirements
Module: cut_latency_monitor

Interface
REQ-001 Parameter DATA_WIDTH, default 88, width of the circuit-under-test (CUT) output word (spongent hash width N).
REQ-002 Parameter CNT_WIDTH, default 32, width of the latency counter.
REQ-003 Parameter TIMEOUT_CYCLES, default 32'h000F_FFFF, RUN-cycle limit; used only when the timeout feature is compiled in.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rst_cut  input  1  CUT reset as driven by the test controller; its 1->0 transition starts a measurement.
REQ-007 end_cut  input  1  CUT completion flag (spongent end_hash).
REQ-008 output_from_cut  input  DATA_WIDTH  CUT result word (spongent hash).
REQ-009 result_ready  input  1  consumer accepts the held result.
REQ-010 result_valid  output  1  a captured result is held.
REQ-011 result_data  output  DATA_WIDTH  captured CUT result.
REQ-012 result_cycles  output  CNT_WIDTH  measured latency in clock cycles.
REQ-013 timeout  output  1  held result was ended by timeout, not by end_cut.
REQ-014 aborted  output  1  one-cycle pulse when a running measurement is cancelled.
REQ-015 overrun  output  1  sticky: a start edge occurred while a result was pending.

Function
REQ-016 The block SHALL register rst_cut into rst_cut_q every cycle; start = rst_cut_q & ~rst_cut.
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-018 IDLE: on start, the counter SHALL load 1 and the FSM SHALL go to RUN; otherwise the FSM stays in IDLE.
REQ-019 RUN: each cycle with rst_cut=0 and end_cut=0, the counter SHALL increment by 1, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-020 RUN, end_cut=1 and rst_cut=0: on that edge, result_data SHALL load output_from_cut, result_cycles SHALL load the current counter value, timeout SHALL load 0, and the FSM SHALL go to DONE.
REQ-021 Latency definition: the first cycle with rst_cut=0 counts as 1; if end_cut is first sampled high N cycles after start, result_cycles=N+1.
REQ-022 RUN, rst_cut=1: the FSM SHALL return to IDLE, assert aborted for exactly one cycle and capture nothing; this takes priority over end_cut and timeout.
REQ-023 DONE: result_valid=1, and result_data, result_cycles and timeout SHALL remain stable.
REQ-024 DONE, result_ready=1: result_valid SHALL drop on the next edge and the FSM SHALL go to IDLE; the outputs keep their last values.
REQ-025 DONE, start: the start SHALL be ignored and overrun SHALL set; only rst clears overrun.
REQ-026 DONE, result_ready=1 and start in the same cycle: the FSM SHALL go to IDLE, not RUN, and overrun SHALL set.
REQ-027 end_cut SHALL be ignored in IDLE and DONE.

Reset
REQ-028 With rst=1 at a clock edge: state=IDLE, counter=0, rst_cut_q=1, result_valid=0, result_data=0, result_cycles=0, timeout=0, aborted=0, overrun=0.
REQ-029 rst SHALL override every other input, including mid-RUN and mid-DONE; a pending result is discarded.

Configuration
REQ-030 Macro CUT_LATENCY_MONITOR_TIMEOUT_EN, when defined: in RUN, if end_cut=0, rst_cut=0 and the counter equals TIMEOUT_CYCLES, the block SHALL go to DONE with result_cycles=TIMEOUT_CYCLES, result_data=0 and timeout=1.
REQ-031 If end_cut=1 in the same cycle as the timeout condition, end_cut SHALL win.
REQ-032 Macro undefined: no timeout logic; timeout SHALL be tied to 0 and RUN persists until end_cut or abort.

Verification
REQ-033 rst_cut 1->0, end_cut high 40 cycles later -> result_valid=1, result_cycles=41, result_data equals output_from_cut at that edge.
REQ-034 result_valid held, result_ready low for 10 cycles, then pulsed high for 1 cycle -> outputs stable throughout; result_valid=0 on the following cycle.
REQ-035 rst_cut reasserted 5 cycles into RUN -> aborted pulses for 1 cycle, result_valid stays 0; a new start then measures correctly.
REQ-036 Start edge during DONE -> overrun=1, result unchanged; rst=1 -> overrun=0 and every output at its reset value.
REQ-037 Macro defined, TIMEOUT_CYCLES=100, end_cut held low -> timeout=1, result_cycles=100, result_data=0.
REQ-038 Macro defined, TIMEOUT_CYCLES=100, end_cut rises on the counter=100 cycle -> timeout=0, result_cycles=100.
